fir_frame_sequencer: RTL and testbench
======================================

Name: fir_frame_sequencer

Overview:
- Sequences one analysis frame through the FIR filter.
- Pulls N_SAMPLES input samples from an upstream source via valid/ready and drives the FIR sample input.
- Appends TAPS zero samples to flush the delay line, then collects exactly N_SAMPLES FIR outputs and forwards them downstream with a last marker.
- Sits between the sample source and the FIR; its outputs feed the frequency-analysis stage.

Parameters:
- N_SAMPLES, 1024, input samples per frame; also the number of outputs forwarded.
- TAPS, 32, FIR tap count; number of flush zeros appended.
- DW, 16, sample width.
- DRAIN_TIMEOUT, 64, maximum idle cycles without fir_valid in DRAIN before abort.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle frame start request.
- src_valid  in  1  upstream sample valid.
- src_data  in  DW  upstream sample.
- src_ready  out  1  sequencer accepts src_data this cycle.
- fir_data_valid  out  1  sample valid to FIR.
- fir_data  out  DW  sample to FIR.
- fir_valid  in  1  FIR output valid.
- fir_d  in  DW  FIR output sample.
- out_valid  out  1  forwarded output valid.
- out_data  out  DW  forwarded output sample.
- out_last  out  1  high with the N_SAMPLES-th forwarded sample.
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle pulse at frame completion, normal or aborted.
- underrun  out  1  sticky flag: source starved during FILL.
- timeout  out  1  sticky flag: DRAIN aborted by timeout.

Behaviour:
Reset:
- Asynchronous; all outputs 0; state IDLE; counters 0.
- Reset mid-frame returns to IDLE immediately. The partial frame is discarded.

State machine:
- IDLE: on start=1, go to FILL and clear underrun, timeout and all counters. Otherwise stay.
- FILL: src_ready=1 every cycle, independent of src_valid.
  - Each cycle registers fir_data_valid=1 and fir_data = src_valid ? src_data : 0.
  - If src_valid=0, underrun is set and the input counter still advances. The FIR must see one sample per cycle.
  - After N_SAMPLES cycles, go to FLUSH.
- FLUSH: src_ready=0, fir_data_valid=1, fir_data=0 for TAPS cycles, then go to DRAIN.
- DRAIN: fir_data_valid=0, fir_data=0. Wait until N_SAMPLES outputs are forwarded, then go to DONE.
  - An idle counter increments on each cycle with fir_valid=0 and resets on fir_valid=1.
  - When the idle counter reaches DRAIN_TIMEOUT, set timeout and go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE.
- start while busy=1 is ignored.

Latency:
- Sample accepted (or substituted) at cycle t appears on fir_data at t+1.
- fir_d captured at cycle t appears on out_data at t+1, registered.

Output forwarding:
- Active in FILL, FLUSH and DRAIN.
- Each fir_valid=1 cycle forwards fir_d and increments the output counter, until the counter reaches N_SAMPLES.
- Further fir_valid is dropped; out_valid stays 0.
- out_last=1 only on the forwarded sample with count N_SAMPLES-1 (0-based).
- out_valid is not asserted in IDLE or DONE.
- Simultaneous last output and a timeout-limit cycle: the output takes precedence. timeout stays 0 and the normal DONE path is taken.

Counters:
- Input counter: clog2(N_SAMPLES+TAPS) bits.
- Output counter: clog2(N_SAMPLES)+1 bits.
- Idle counter: clog2(DRAIN_TIMEOUT)+1 bits.
- No wrap occurs within a frame; all counters clear on entering FILL.

Flags:
- underrun and timeout hold until the next accepted start or reset.
- Downstream has no backpressure; out_valid is a pure strobe.

Optional Feature:
- Macro: FIR_SEQ_UNDERRUN_HOLD_EN.
- Defined: on an underrun cycle in FILL, fir_data repeats the last sample driven. If no sample has yet been driven in this frame, it drives 0. underrun is still set.
- Undefined: an underrun cycle drives 0.

Test Plan:
1. Reset, start, src_valid=1 with src_data=n for n=0..1023:
   - fir_data_valid high exactly 1056 cycles; last 32 with fir_data=0.
   - underrun=0.
   - Model FIR emitting 1024 outputs produces 1024 out_valid, out_last on the 1024th.
   - done pulses once; busy falls the cycle after done.
2. Drop src_valid for 3 cycles at sample 100:
   - underrun=1.
   - fir_data at those 3 slots = 0; with FIR_SEQ_UNDERRUN_HOLD_EN, = 99.
   - Total FIR input cycles still 1056.
3. Model FIR stops after 500 outputs:
   - timeout=1 exactly 64 idle cycles after the 500th fir_valid.
   - done pulses; out_last never asserted.
4. Model FIR emits 1030 valid outputs:
   - Only the first 1024 are forwarded; outputs 1025-1030 are dropped.
5. Assert start again at sample 300:
   - Ignored; frame completes normally.
   - Then assert rst low at sample 600 of a new frame: all outputs 0 asynchronously, state IDLE, and a subsequent start runs a clean frame with flags cleared.

Source files
------------

// File: rtl/fir_frame_sequencer.sv
// Frame sequencer for the FIR: N_SAMPLES source samples, TAPS flush zeros, then N_SAMPLES outputs forwarded.
// Optional: define FIR_SEQ_UNDERRUN_HOLD_EN to repeat the last driven sample on underrun instead of 0.
module fir_frame_sequencer #(
   parameter int N_SAMPLES     = 1024,
   parameter int TAPS          = 32,
   parameter int DW            = 16,
   parameter int DRAIN_TIMEOUT = 64
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic          src_valid,
   input  logic [DW-1:0] src_data,
   output logic          src_ready,
   output logic          fir_data_valid,
   output logic [DW-1:0] fir_data,
   input  logic          fir_valid,
   input  logic [DW-1:0] fir_d,
   output logic          out_valid,
   output logic [DW-1:0] out_data,
   output logic          out_last,
   output logic          busy,
   output logic          done,
   output logic          underrun,
   output logic          timeout
);

   localparam int IN_W   = $clog2(N_SAMPLES + TAPS);
   localparam int OUT_W  = $clog2(N_SAMPLES) + 1;
   localparam int IDLE_W = $clog2(DRAIN_TIMEOUT) + 1;

   localparam logic [IN_W-1:0]   FILL_END   = IN_W'(N_SAMPLES - 1);
   localparam logic [IN_W-1:0]   FLUSH_END  = IN_W'(N_SAMPLES + TAPS - 1);
   localparam logic [OUT_W-1:0]  OUT_LAST   = OUT_W'(N_SAMPLES - 1);
   localparam logic [OUT_W-1:0]  OUT_FULL   = OUT_W'(N_SAMPLES);
   localparam logic [IDLE_W-1:0] IDLE_LIMIT = IDLE_W'(DRAIN_TIMEOUT);

   typedef enum logic [2:0] {
      IDLE,
      FILL,
      FLUSH,
      DRAIN,
      DONE
   } state_t;

   state_t            state, state_nxt;
   logic [IN_W-1:0]   in_cnt, in_cnt_nxt;
   logic [OUT_W-1:0]  out_cnt, out_cnt_nxt;
   logic [IDLE_W-1:0] idle_cnt, idle_cnt_nxt;
   logic              underrun_nxt, timeout_nxt;
   logic              fir_data_valid_nxt;
   logic [DW-1:0]     fir_data_nxt;
   logic [DW-1:0]     starve_data;
   logic              fwd_active, fwd, last_fwd, frame_start;

   // fir_data already holds the last sample driven this frame (0 right after IDLE).
`ifdef FIR_SEQ_UNDERRUN_HOLD_EN
   assign starve_data = fir_data;
`else
   assign starve_data = '0;
`endif

   assign src_ready   = (state == FILL);
   assign busy        = (state != IDLE);
   assign done        = (state == DONE);
   assign frame_start = (state == IDLE) && start;

   assign fwd_active = (state == FILL) || (state == FLUSH) || (state == DRAIN);
   assign fwd        = fwd_active && fir_valid && (out_cnt != OUT_FULL);
   assign last_fwd   = fwd && (out_cnt == OUT_LAST);

   always_comb begin
      // NOTE: every combinationally assigned signal gets a default first so no path infers a latch.
      state_nxt          = state;
      in_cnt_nxt         = in_cnt;
      idle_cnt_nxt       = idle_cnt;
      underrun_nxt       = underrun;
      timeout_nxt        = timeout;
      fir_data_valid_nxt = 1'b0;
      fir_data_nxt       = '0;

      case (state)
         IDLE: begin
            if (start) begin
               state_nxt    = FILL;
               in_cnt_nxt   = '0;
               idle_cnt_nxt = '0;
               underrun_nxt = 1'b0;
               timeout_nxt  = 1'b0;
            end
         end
         FILL: begin
            // The FIR needs one sample per cycle, so a starved slot is substituted, not skipped.
            fir_data_valid_nxt = 1'b1;
            fir_data_nxt       = src_valid ? src_data : starve_data;
            if (!src_valid) underrun_nxt = 1'b1;
            in_cnt_nxt = in_cnt + 1'b1;
            if (in_cnt == FILL_END) state_nxt = FLUSH;
         end
         FLUSH: begin
            fir_data_valid_nxt = 1'b1;
            in_cnt_nxt         = in_cnt + 1'b1;
            if (in_cnt == FLUSH_END) state_nxt = DRAIN;
         end
         DRAIN: begin
            idle_cnt_nxt = fir_valid ? '0 : idle_cnt + 1'b1;
            if (out_cnt == OUT_FULL) begin
               state_nxt = DONE;
            end else if (!fir_valid && !last_fwd && (idle_cnt + 1'b1 == IDLE_LIMIT)) begin
               timeout_nxt = 1'b1;
               state_nxt   = DONE;
            end
         end
         DONE: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      out_cnt_nxt = out_cnt;
      if (frame_start) out_cnt_nxt = '0;
      else if (fwd)    out_cnt_nxt = out_cnt + 1'b1;
   end

   // NOTE: state uses non-blocking assignments and an asynchronous reset so every register
   // settles together and a mid-frame reset drops the partial frame at once.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state          <= IDLE;
         in_cnt         <= '0;
         out_cnt        <= '0;
         idle_cnt       <= '0;
         underrun       <= 1'b0;
         timeout        <= 1'b0;
         fir_data_valid <= 1'b0;
         fir_data       <= '0;
      end else begin
         state          <= state_nxt;
         in_cnt         <= in_cnt_nxt;
         out_cnt        <= out_cnt_nxt;
         idle_cnt       <= idle_cnt_nxt;
         underrun       <= underrun_nxt;
         timeout        <= timeout_nxt;
         fir_data_valid <= fir_data_valid_nxt;
         fir_data       <= fir_data_nxt;
      end
   end

   // Downstream has no backpressure: out_valid is a one-cycle strobe per forwarded sample.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_last  <= 1'b0;
      end else begin
         out_valid <= fwd;
         out_last  <= last_fwd;
         if (fwd) out_data <= fir_d;
      end
   end

endmodule

// File: tb/tb_fir_frame_sequencer.sv
// Scoreboard bench for fir_frame_sequencer: drives source and a behavioural FIR, checks fir_data and forwarded outputs.
module tb_fir_frame_sequencer;

   localparam int N    = 1024;
   localparam int TAPS = 32;
   localparam int DW   = 16;
   localparam int TMO  = 64;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          start = 1'b0;
   logic          src_valid = 1'b0;
   logic [DW-1:0] src_data = '0;
   logic          src_ready;
   logic          fir_data_valid;
   logic [DW-1:0] fir_data;
   logic          fir_valid = 1'b0;
   logic [DW-1:0] fir_d = '0;
   logic          out_valid;
   logic [DW-1:0] out_data;
   logic          out_last;
   logic          busy;
   logic          done;
   logic          underrun;
   logic          timeout;

   int vectors     = 0;
   int miscompares = 0;

   logic [DW-1:0] exp_fir_q[$];
   logic [DW-1:0] exp_out_q[$];

   fir_frame_sequencer #(
      .N_SAMPLES(N), .TAPS(TAPS), .DW(DW), .DRAIN_TIMEOUT(TMO)
   ) dut (
      .clk(clk), .rst(rst), .start(start),
      .src_valid(src_valid), .src_data(src_data), .src_ready(src_ready),
      .fir_data_valid(fir_data_valid), .fir_data(fir_data),
      .fir_valid(fir_valid), .fir_d(fir_d),
      .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
      .busy(busy), .done(done), .underrun(underrun), .timeout(timeout)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      vectors++;
      if (got !== want) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, want, $time);
      end
   endtask

   function automatic logic [DW-1:0] fir_val(input int k);
      return DW'(k * 37 + 11) ^ 16'h5a00;
   endfunction

   // Inputs are driven and outputs sampled at negedge, away from the active edge.
   task automatic run_frame(input int emit_total, input int emit_start, input bit gappy,
                            input int drop_at, input int drop_len, input int restart_at,
                            input int reset_at, input bit exp_underrun, input bit exp_timeout);
      int cyc = 0, s = 0, k = 0, fir_in = 0, outs = 0, dones = 0;
      int last_fir_cyc = -1, to_cyc = -1;
      bit last_seen = 1'b0, done_prev = 1'b0, finished = 1'b0;
      logic [DW-1:0] last_drv = '0, v, hold, want;
      exp_fir_q.delete();
      exp_out_q.delete();
      @(negedge clk);
      start = 1'b1;
      while (cyc < 4000) begin
         @(negedge clk);
         cyc++;
         if (done_prev) begin
            check("busy_after_done", busy, 1'b0);
            finished = 1'b1;
            break;
         end
         if (fir_data_valid) begin
            fir_in++;
            if (exp_fir_q.size() == 0) check("fir_extra", 1, 0);
            else begin
               want = exp_fir_q.pop_front();
               check("fir_data", fir_data, want);
            end
         end
         if (out_valid) begin
            outs++;
            if (exp_out_q.size() == 0) check("out_extra", 1, 0);
            else begin
               want = exp_out_q.pop_front();
               check("out_data", out_data, want);
            end
            check("out_last", out_last, outs == N);
            if (out_last) last_seen = 1'b1;
         end else if (out_last) begin
            check("out_last_stray", out_last, 1'b0);
         end
         if (done) dones++;
         done_prev = done;
         if (timeout && to_cyc < 0) to_cyc = cyc;

         start = (restart_at >= 0) && (s == restart_at);
         if (reset_at >= 0 && s == reset_at) begin
            #2 rst = 1'b0;
            #1;
            check("rst_busy", busy, 1'b0);
            check("rst_underrun", underrun, 1'b0);
            check("rst_data", {fir_data, out_data}, 32'd0);
            check("rst_strobes", {src_ready, fir_data_valid, out_valid, out_last, done, timeout}, 32'd0);
            start = 1'b0;
            src_valid = 1'b0;
            fir_valid = 1'b0;
            @(negedge clk);
            rst = 1'b1;
            return;
         end

         if (src_ready) begin
            src_valid = !(s >= drop_at && s < drop_at + drop_len);
            src_data  = DW'(s);
`ifdef FIR_SEQ_UNDERRUN_HOLD_EN
            hold = last_drv;
`else
            hold = '0;
`endif
            v = src_valid ? src_data : hold;
            exp_fir_q.push_back(v);
            last_drv = v;
            s++;
            if (s == N) repeat (TAPS) exp_fir_q.push_back('0);
         end else begin
            src_valid = 1'b0;
            src_data  = '0;
         end

         if (cyc >= emit_start && k < emit_total && !(gappy && cyc % 9 == 0)) begin
            fir_valid = 1'b1;
            fir_d     = fir_val(k);
            if (k < N) exp_out_q.push_back(fir_d);
            k++;
            last_fir_cyc = cyc;
         end else begin
            fir_valid = 1'b0;
            fir_d     = '0;
         end
      end

      check("frame_finished", finished, 1'b1);
      check("fir_in_cycles", fir_in, N + TAPS);
      check("fir_q_empty", exp_fir_q.size(), 0);
      check("out_count", outs, (emit_total < N) ? emit_total : N);
      check("out_q_empty", exp_out_q.size(), 0);
      check("out_last_seen", last_seen, emit_total >= N);
      check("done_pulses", dones, 1);
      check("underrun", underrun, exp_underrun);
      check("timeout", timeout, exp_timeout);
      if (exp_timeout) check("timeout_delay", to_cyc - last_fir_cyc, TMO + 1);

      // Surplus FIR outputs while idle must never be forwarded.
      repeat (8) begin
         @(negedge clk);
         check("idle_out_valid", out_valid, 1'b0);
         fir_valid = 1'b1;
         fir_d     = DW'($urandom);
      end
      @(negedge clk);
      fir_valid = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      #3;
      check("reset_busy", busy, 1'b0);
      check("reset_strobes", {src_ready, fir_data_valid, out_valid, out_last, done, underrun, timeout}, 32'd0);
      check("reset_data", {fir_data, out_data}, 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;

      run_frame(1024, 40,   1'b1, -1,  0, -1,  -1, 1'b0, 1'b0);  // clean frame, gappy FIR
      run_frame(1024, 40,   1'b0, 100, 3, -1,  -1, 1'b1, 1'b0);  // 3-cycle source starvation
      run_frame(500,  1080, 1'b0, -1,  0, -1,  -1, 1'b0, 1'b1);  // FIR stalls, drain timeout
      run_frame(1030, 40,   1'b0, -1,  0, -1,  -1, 1'b0, 1'b0);  // surplus FIR outputs dropped
      run_frame(1024, 40,   1'b0, -1,  0, 300, -1, 1'b0, 1'b0);  // start while busy ignored
      run_frame(1024, 40,   1'b0, 10,  2, -1, 600, 1'b1, 1'b0);  // reset mid-frame
      run_frame(1024, 40,   1'b1, -1,  0, -1,  -1, 1'b0, 1'b0);  // clean frame after reset

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
